// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one RAM port between the icache and dcache miss
// channels. One requester is granted at a time. The grant is held until the
// RAM reports ACCESS, ERROR or a timeout, or until the requester withdraws.
//
// Handshake: a requester raises its request (iREN, or dREN/dWEN) and holds
// its address and data stable while its wait output is 1. Its wait output is
// 0 for exactly one cycle, the completion cycle. In that cycle load carries
// the RAM read data; this happens when the RAM reports ACCESS during the
// grant. A requester that drops its request before completion aborts the
// access and gets no completion.
//
// Optional build macro: ARB_ROUND_ROBIN_EN. When it is defined, a one-bit
// last-served register breaks ties in IDLE when both caches request. When it
// is undefined, the dcache always wins ties.
module cache_mem_arbiter #(
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              err_timeout,
  output logic [1:0]        state_dbg_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IGRANT  = 2'd1,
    ST_DGRANT  = 2'd2,
    ST_RECOVER = 2'd3
  } state_e;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;
  // Compared in 9 bits so the limit test stays correct at the top of the
  // 8-bit counter range.
  localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       d_req;
  logic       pick_d;
  logic       cnt_at_limit;
  logic [7:0] cnt_inc;

`ifdef ARB_ROUND_ROBIN_EN
  // 0 = icache was served last, 1 = dcache was served last.
  logic last_q, last_d;
`endif

  assign d_req        = dREN | dWEN;
  // The counter holds the number of non-completing grant cycles so far.
  // The limit is reached when this cycle would become the TIMEOUT-th one.
  assign cnt_at_limit = ({1'b0, cnt_q} + 9'd1) >= TIMEOUT_LIM;
  assign cnt_inc      = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  assign err_timeout  = err_q;
  assign state_dbg_o  = state_q;

  // Tie-break between simultaneous requests seen in IDLE.
`ifdef ARB_ROUND_ROBIN_EN
  assign pick_d = d_req & (~iREN | ~last_q);
`else
  assign pick_d = d_req;
`endif

  // State, timeout counter and sticky error flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Last-served tracker. It changes only on a completion.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // Next-state and output decode. All RAM-side outputs come from the live
  // inputs of the granted requester, so a withdrawn request drops the
  // strobes in the same cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d   = last_q;
`endif
    iwait    = 1'b1;
    iload    = '0;
    dwait    = 1'b1;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;

    case (state_q)
      ST_IDLE: begin
        if (pick_d) begin
          state_d = ST_DGRANT;
          cnt_d   = 8'd0;
        end else if (iREN) begin
          state_d = ST_IGRANT;
          cnt_d   = 8'd0;
        end
      end

      ST_IGRANT: begin
        if (!iREN) begin
          state_d = ST_IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ramstate == RAM_ACCESS) begin
            iwait   = 1'b0;
            iload   = ramload;
            state_d = ST_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
            last_d  = 1'b0;
`endif
          end else if (ramstate == RAM_ERROR) begin
            state_d = ST_RECOVER;
          end else if (cnt_at_limit) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end else begin
            cnt_d   = cnt_inc;
          end
        end
      end

      ST_DGRANT: begin
        if (!d_req) begin
          state_d = ST_IDLE;
        end else begin
          // A simultaneous read and write request is served as a write.
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          if (ramstate == RAM_ACCESS) begin
            dwait   = 1'b0;
            dload   = dWEN ? '0 : ramload;
            state_d = ST_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
            last_d  = 1'b1;
`endif
          end else if (ramstate == RAM_ERROR) begin
            state_d = ST_RECOVER;
          end else if (cnt_at_limit) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end else begin
            cnt_d   = cnt_inc;
          end
        end
      end

      ST_RECOVER: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed testbench for cache_mem_arbiter, built with TIMEOUT=4. Inputs
// change 1 time unit after the rising edge. Outputs are sampled 1 time unit
// later, so they are never sampled on a clock edge.
module tb_cache_mem_arbiter;

  localparam int W = 32;
  localparam logic [31:0] S_IDLE = 32'd0;
  localparam logic [31:0] S_IGNT = 32'd1;
  localparam logic [31:0] S_DGNT = 32'd2;
  localparam logic [31:0] S_RECV = 32'd3;
  localparam logic [1:0]  R_FREE = 2'd0;
  localparam logic [1:0]  R_BUSY = 2'd1;
  localparam logic [1:0]  R_ACC  = 2'd2;
  localparam logic [1:0]  R_ERR  = 2'd3;

  logic         CLK;
  logic         RST;
  logic         iREN;
  logic [W-1:0] iaddr;
  logic         iwait;
  logic [W-1:0] iload;
  logic         dREN;
  logic         dWEN;
  logic [W-1:0] daddr;
  logic [W-1:0] dstore;
  logic         dwait;
  logic [W-1:0] dload;
  logic         ramREN;
  logic         ramWEN;
  logic [W-1:0] ramaddr;
  logic [W-1:0] ramstore;
  logic [W-1:0] ramload;
  logic [1:0]   ramstate;
  logic         err_timeout;
  logic [1:0]   state_dbg_o;

  int n_checks;
  int n_pass;
  logic [W-1:0] exp_q[$];

  cache_mem_arbiter #(.WORD_W(W), .TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
    .err_timeout(err_timeout), .state_dbg_o(state_dbg_o)
  );

  // Clock and watchdog
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, need end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, need 0x%08h", tag, got, exp);
  endtask

  // Move to 1 time unit after the next rising edge, where inputs are driven.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic ir, input logic [W-1:0] ia,
                       input logic dr, input logic dw, input logic [W-1:0] da,
                       input logic [W-1:0] ds, input logic [1:0] rs,
                       input logic [W-1:0] rl);
    iREN = ir; iaddr = ia; dREN = dr; dWEN = dw; daddr = da; dstore = ds;
    ramstate = rs; ramload = rl;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    RST = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, R_FREE, '0);
    #2;
    check("rst_state", 32'(state_dbg_o), S_IDLE);
    check("rst_iwait", 32'(iwait), 32'd1);
    check("rst_dwait", 32'(dwait), 32'd1);
    check("rst_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
    check("rst_addr", ramaddr | ramstore | iload | dload, 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    #11 RST = 1'b0;

    // Single icache read: three BUSY cycles, then ACCESS.
    next_cycle();
    drive(1'b1, 32'h100, 1'b0, 1'b0, '0, '0, R_FREE, '0);
    exp_q.push_back(32'hDEADBEEF);
    settle();
    check("i1_idle_wait", 32'(iwait), 32'd1);
    check("i1_idle_ren", 32'(ramREN), 32'd0);
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      ramstate = R_BUSY;
      settle();
      check("i1_grant_state", 32'(state_dbg_o), S_IGNT);
      check("i1_grant_ren", 32'(ramREN), 32'd1);
      check("i1_grant_addr", ramaddr, 32'h100);
      check("i1_grant_wait", 32'(iwait), 32'd1);
    end
    next_cycle();
    ramstate = R_ACC; ramload = 32'hDEADBEEF;
    settle();
    check("i1_done_wait", 32'(iwait), 32'd0);
    check("i1_done_load", iload, exp_q.pop_front());
    check("i1_done_dwait", 32'(dwait), 32'd1);
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, R_FREE, '0);
    settle();
    check("i1_after_state", 32'(state_dbg_o), S_IDLE);
    check("i1_after_wait", 32'(iwait), 32'd1);

    // Contention: the dcache write wins first, then the icache read follows.
    next_cycle();
    drive(1'b1, 32'h104, 1'b0, 1'b1, 32'h200, 32'h12345678, R_FREE, '0);
    settle();
    next_cycle();
    ramstate = R_ACC; ramload = 32'hFFFF0000;
    settle();
    check("c_dgrant_state", 32'(state_dbg_o), S_DGNT);
    check("c_dgrant_wen", {30'd0, ramWEN, ramREN}, 32'd2);
    check("c_dgrant_addr", ramaddr, 32'h200);
    check("c_dgrant_store", ramstore, 32'h12345678);
    check("c_dgrant_dwait", 32'(dwait), 32'd0);
    check("c_dgrant_dload", dload, 32'd0);
    check("c_dgrant_iwait", 32'(iwait), 32'd1);
    check("c_dgrant_iload", iload, 32'd0);
    next_cycle();
    dWEN = 1'b0; ramstate = R_FREE;
    settle();
    check("c_gap_state", 32'(state_dbg_o), S_IDLE);
    check("c_gap_ren", 32'(ramREN), 32'd0);
    next_cycle();
    ramstate = R_ACC; ramload = 32'hCAFEF00D;
    exp_q.push_back(32'hCAFEF00D);
    settle();
    check("c_igrant_state", 32'(state_dbg_o), S_IGNT);
    check("c_igrant_addr", ramaddr, 32'h104);
    check("c_igrant_iwait", 32'(iwait), 32'd0);
    check("c_igrant_iload", iload, exp_q.pop_front());
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, R_FREE, '0);

    // RAM ERROR in the first grant cycle goes through RECOVER and is
    // arbitrated again.
    next_cycle();
    dREN = 1'b1; daddr = 32'h300;
    settle();
    next_cycle();
    ramstate = R_ERR;
    settle();
    check("e_grant_ren", 32'(ramREN), 32'd1);
    check("e_grant_dwait", 32'(dwait), 32'd1);
    next_cycle();
    ramstate = R_FREE;
    settle();
    check("e_recover_state", 32'(state_dbg_o), S_RECV);
    check("e_recover_ren", {30'd0, ramREN, ramWEN}, 32'd0);
    check("e_recover_addr", ramaddr, 32'd0);
    check("e_recover_dwait", 32'(dwait), 32'd1);
    next_cycle();
    settle();
    check("e_idle_state", 32'(state_dbg_o), S_IDLE);
    check("e_idle_dwait", 32'(dwait), 32'd1);
    next_cycle();
    ramstate = R_ACC; ramload = 32'h55AA55AA;
    settle();
    check("e_regrant_state", 32'(state_dbg_o), S_DGNT);
    check("e_regrant_dwait", 32'(dwait), 32'd0);
    check("e_regrant_dload", dload, 32'h55AA55AA);
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, R_FREE, '0);

    // Timeout with TIMEOUT=4: four BUSY grant cycles, then IDLE and a sticky
    // error flag.
    next_cycle();
    dREN = 1'b1; daddr = 32'h400; ramstate = R_BUSY;
    settle();
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      settle();
      check("t_grant_state", 32'(state_dbg_o), S_DGNT);
      check("t_grant_err", 32'(err_timeout), 32'd0);
      check("t_grant_dwait", 32'(dwait), 32'd1);
    end
    next_cycle();
    settle();
    check("t_abort_state", 32'(state_dbg_o), S_IDLE);
    check("t_abort_err", 32'(err_timeout), 32'd1);
    next_cycle();
    settle();
    check("t_regrant_state", 32'(state_dbg_o), S_DGNT);
    check("t_regrant_err", 32'(err_timeout), 32'd1);
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, R_FREE, '0);

    // The icache withdraws its request mid-grant. The RAM reports ACCESS in
    // that cycle, and still no completion may reach the icache.
    next_cycle();
    iREN = 1'b1; iaddr = 32'h500; ramstate = R_BUSY;
    settle();
    next_cycle();
    settle();
    check("a_grant_ren", 32'(ramREN), 32'd1);
    next_cycle();
    iREN = 1'b0; ramstate = R_ACC; ramload = 32'h11111111;
    settle();
    check("a_drop_ren", 32'(ramREN), 32'd0);
    check("a_drop_addr", ramaddr, 32'd0);
    check("a_drop_iwait", 32'(iwait), 32'd1);
    check("a_drop_iload", iload, 32'd0);
    next_cycle();
    ramstate = R_FREE;
    settle();
    check("a_after_state", 32'(state_dbg_o), S_IDLE);
    check("a_err_sticky", 32'(err_timeout), 32'd1);

    // Asynchronous reset in the middle of a dcache write grant.
    next_cycle();
    dWEN = 1'b1; daddr = 32'h600; dstore = 32'h77; ramstate = R_BUSY;
    settle();
    next_cycle();
    settle();
    check("r_grant_wen", 32'(ramWEN), 32'd1);
    #2 RST = 1'b1;
    #1;
    check("r_async_state", 32'(state_dbg_o), S_IDLE);
    check("r_async_wen", {30'd0, ramREN, ramWEN}, 32'd0);
    check("r_async_addr", ramaddr | ramstore, 32'd0);
    check("r_async_dwait", 32'(dwait), 32'd1);
    check("r_async_err", 32'(err_timeout), 32'd0);
    #3 RST = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, R_FREE, '0);
    next_cycle();
    settle();
    check("r_after_state", 32'(state_dbg_o), S_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
